// File: rtl/led_pattern_ctrl_if.sv
// Button inputs and LED bar outputs of the LED pattern controller.
// The master side drives the raw buttons; the slave side is the controller.
interface led_pattern_ctrl_if;
   logic       BUT1;
   logic       BUT2;
   logic [7:0] LED;
   logic [2:0] POS;
   logic [1:0] MODE;

   modport master (output BUT1, BUT2, input LED, POS, MODE);
   modport slave  (input BUT1, BUT2, output LED, POS, MODE);
endinterface

// File: rtl/led_pattern_ctrl.sv
// Two-button LED bar controller: synchronize and debounce the buttons, then run
// a MANUAL / AUTO_UP / AUTO_DOWN / PAUSE machine that moves a one-hot LED.
module led_pattern_ctrl #(
   parameter int CLK_DIV     = 1000000,
   parameter int DEB_SAMPLES = 3,
   parameter int STEP_TICKS  = 25
) (
   input  logic               CLK,
   input  logic               RST_N,
   led_pattern_ctrl_if.slave  io
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

   typedef enum logic [1:0] {MANUAL = 2'd0, AUTO_UP = 2'd1, AUTO_DOWN = 2'd2, PAUSE = 2'd3} mode_t;

   logic [CW-1:0]                tick_cnt;
   logic                         tick;
   logic [1:0]                   sync1, sync2, deb, deb_q, press, ev;
   logic [1:0][DEB_SAMPLES-1:0]  hist, hist_nxt;
   logic                         chord, in_auto, step;
   logic [SW-1:0]                step_cnt;
   mode_t                        state, state_nxt;
   logic                         dir_up, dir_nxt;
   logic [2:0]                   pos, pos_nxt;
   logic [7:0]                   led;

   assign tick = (tick_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge CLK) begin
      if (!RST_N) tick_cnt <= '0;
      else        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
   end

   // Index 0 is BUT1, index 1 is BUT2 throughout.
   always_comb begin
      for (int b = 0; b < 2; b++)
         hist_nxt[b] = DEB_SAMPLES'({hist[b], sync2[b]});
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
         deb   <= '0;
         deb_q <= '0;
      end else begin
         sync1 <= {io.BUT2, io.BUT1};
         sync2 <= sync1;
         deb_q <= deb;
         if (tick) begin
            hist <= hist_nxt;
            for (int b = 0; b < 2; b++) begin
               if (&hist_nxt[b])       deb[b] <= 1'b1;
               else if (~|hist_nxt[b]) deb[b] <= 1'b0;
            end
         end
      end
   end

   // A chord swallows both individual presses.
   assign press = deb & ~deb_q;
   assign chord = (&press) | (press[0] & deb[1]) | (press[1] & deb[0]);
   assign ev    = press & {2{~chord}};

   assign in_auto = (state == AUTO_UP) || (state == AUTO_DOWN);
   assign step    = in_auto && tick && (step_cnt == SW'(STEP_TICKS - 1)) && !(|press);

   // Any press in an auto state leaves or re-enters auto, so clearing here
   // guarantees a fresh count on every entry.
   always_ff @(posedge CLK) begin
      if (!RST_N || !in_auto || |press) step_cnt <= '0;
      else if (tick)                    step_cnt <= step ? '0 : step_cnt + SW'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= MANUAL;
         dir_up <= 1'b1;
         pos    <= '0;
         led    <= 8'h01;
      end else begin
         state  <= state_nxt;
         dir_up <= dir_nxt;
         pos    <= pos_nxt;
         led    <= 8'b1 << pos_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         MANUAL:    if (chord) state_nxt = AUTO_UP;
         AUTO_UP:   if (chord) state_nxt = MANUAL;
                    else if (ev[0]) state_nxt = PAUSE;
                    else if (ev[1]) state_nxt = AUTO_DOWN;
         AUTO_DOWN: if (chord) state_nxt = MANUAL;
                    else if (ev[0]) state_nxt = PAUSE;
                    else if (ev[1]) state_nxt = AUTO_UP;
         PAUSE:     if (chord) state_nxt = MANUAL;
                    else if (ev[0]) state_nxt = dir_up ? AUTO_UP : AUTO_DOWN;
                    else if (ev[1]) state_nxt = dir_up ? AUTO_DOWN : AUTO_UP;
         default:   state_nxt = MANUAL;
      endcase
   end

   // Only MANUAL presses and auto steps move the bar; mode changes never do.
   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir_up;
      if (state_nxt == AUTO_UP)        dir_nxt = 1'b1;
      else if (state_nxt == AUTO_DOWN) dir_nxt = 1'b0;
      unique case (state)
         MANUAL:    if (ev[0]) pos_nxt = pos + 3'd1;
                    else if (ev[1]) pos_nxt = pos - 3'd1;
         AUTO_UP:   if (step) pos_nxt = pos + 3'd1;
         AUTO_DOWN: if (step) pos_nxt = pos - 3'd1;
         default:   pos_nxt = pos;
      endcase
   end

   assign io.POS  = pos;
   assign io.LED  = led;
   assign io.MODE = state;
endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1000000, CLK cycles per debounce/step tick.
REQ-002 Parameter DEB_SAMPLES, default 3, consecutive equal tick samples required to change a debounced level.
REQ-003 Parameter STEP_TICKS, default 25, ticks between automatic position steps.
REQ-004 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 BUT1  input  1  raw asynchronous button, active-high; "up/run" requester.
REQ-007 BUT2  input  1  raw asynchronous button, active-high; "down/reverse" requester.
REQ-008 LED  output  8  registered one-hot LED bar, LED == 1 << POS at all times.
REQ-009 POS  output  3  registered current LED position.
REQ-010 MODE  output  2  registered FSM state: 0 MANUAL, 1 AUTO_UP, 2 AUTO_DOWN, 3 PAUSE.

Function
REQ-011 Tick counter SHALL count 0..CLK_DIV-1 and wrap; tick is a one-cycle internal pulse when count == CLK_DIV-1; counter width sized for CLK_DIV (no truncation).
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 On each tick, synchronized button is shifted into a DEB_SAMPLES-bit history; debounced level goes 1 when all bits 1, goes 0 when all bits 0, otherwise holds.
REQ-014 Press event = one-cycle pulse on debounced 0->1 transition; releases generate no event.
REQ-015 Chord event SHALL fire when both press events occur in the same cycle, or one press event occurs while the other debounced level is 1; a chord replaces (suppresses) the individual press actions.
REQ-016 MANUAL: BUT1 press -> POS+1; BUT2 press -> POS-1; chord -> AUTO_UP.
REQ-017 AUTO_UP: step POS+1 each STEP_TICKS ticks; BUT1 press -> PAUSE; BUT2 press -> AUTO_DOWN; chord -> MANUAL.
REQ-018 AUTO_DOWN: step POS-1 each STEP_TICKS ticks; BUT1 press -> PAUSE; BUT2 press -> AUTO_UP; chord -> MANUAL.
REQ-019 PAUSE: POS frozen, stored direction retained; BUT1 press -> resume stored direction; BUT2 press -> resume opposite direction; chord -> MANUAL.
REQ-020 Position arithmetic SHALL be modulo 8: 7+1 -> 0, 0-1 -> 7, no saturation.
REQ-021 Step tick counter SHALL clear on every entry into AUTO_UP/AUTO_DOWN; first auto step occurs on the STEP_TICKS-th tick after entry.
REQ-022 If an auto step and a press event coincide in one cycle, the press event wins and the auto step is discarded.
REQ-023 Press-to-output latency: POS, LED and MODE SHALL update on the edge after the press-event cycle (1 cycle); POS and LED always change on the same edge.
REQ-024 Direction changes and pause/resume SHALL NOT move POS in the transition cycle.

Reset
REQ-025 While RST_N == 0 at a CLK edge: POS = 0, LED = 8'h01, MODE = 0 (MANUAL), stored direction = up, tick and step counters = 0, synchronizers, histories and debounced levels = 0.
REQ-026 Reset asserted mid-operation (any state, any counter value) SHALL take effect on the next edge; buttons held through reset release yield a press event only after DEB_SAMPLES ticks of 1.

Verification (CLK_DIV=4, DEB_SAMPLES=3, STEP_TICKS=2)
REQ-027 Reset, BUT1 held high -> no change for 3 ticks, then POS 0->1, LED 8'h01->8'h02 one cycle after press event; held longer -> no further steps.
REQ-028 MANUAL, POS=0, BUT2 press -> POS=7, LED=8'h80; POS=7, BUT1 press -> POS=0.
REQ-029 BUT1 held then BUT2 pressed -> chord, MODE=1, POS unchanged by the chord; LED advances every 2 ticks (8 cycles) 0->1->2...
REQ-030 AUTO_UP: BUT1 press -> MODE=3 POS frozen; BUT2 press -> MODE=2, POS decrements every 8 cycles.
REQ-031 Glitch: BUT1 high for 2 ticks then low -> no event, POS and MODE unchanged.
REQ-032 MODE=2, POS=5, RST_N low for one edge -> POS=0, LED=8'h01, MODE=0 next cycle.
